pulse_pacer: RTL and testbench

- Fast-domain stage that sits directly upstream of the team's toggle-based fast→slow 1-bit pulse synchronizer.
- Accepts bursty single-cycle pulses on clk_f and queues them as a pending count.
- Re-emits them as single-cycle pulses spaced at least GAP clk_f cycles apart, so the slow domain never loses a toggle.
- Flags pulses dropped when the backlog saturates.

---
 rtl/pulse_pacer_pkg.sv | 21 ++
 rtl/pacer_sat_cnt.sv | 54 +++++
 rtl/pulse_pacer.sv | 117 +++++++++++
 tb/tb_pulse_pacer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_pacer_pkg.sv
// ============================================================================
//  Module      : pulse_pacer_pkg
//  Description : Shared state encoding and constants for pulse_pacer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pulse_pacer_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_GAP  = 2'd2
    } pacer_state_e;

endpackage

`default_nettype wire

// File: rtl/pacer_sat_cnt.sv
// ============================================================================
//  Module      : pacer_sat_cnt
//  Description : Saturating up/down counter with synchronous clear, full flag
//                and a drop strobe for increments lost at saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pacer_sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         drop_o
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        full_o = (cnt_q == MAX_VAL);
        drop_o = inc_i && full_o && !dec_i;
        cnt_d  = cnt_q;
        // A clear still honours an increment landing in the same cycle.
        if (clr_i) begin
            cnt_d = (inc_i && !dec_i) ? W'(1) : '0;
        end else if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + W'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pulse_pacer.sv
// ============================================================================
//  Module      : pulse_pacer
//  Description : Queues bursty clk_f pulses and re-emits them at least GAP
//                cycles apart for a toggle fast->slow synchronizer.
//                Define PACER_DROP_CNT_EN to add the drop_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int GAP   = 6,
    parameter int CNT_W = 4
) (
    input  logic                  clk_f,
    input  logic                  rst_n,
    input  logic                  pulse_in,
    input  logic                  clr_ovf,
    output logic                  pulse_out,
    output logic [CNT_W-1:0]      pending,
    output logic                  busy,
`ifdef PACER_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic                  ovf
);

    localparam int             GW       = $clog2(GAP);
    localparam logic [GW-1:0]  GAP_LOAD = GW'(GAP - 1);

    pacer_state_e  state_q, state_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          pulse_q;
    logic          ovf_q, ovf_d;
    logic          w_fire;
    logic          w_drop;
    logic          w_unused_pfull;

    assign w_fire = (state_q == S_FIRE);

    pacer_sat_cnt #(
        .W      (CNT_W)
    ) u_pending (
        .clk    (clk_f),
        .rst_n  (rst_n),
        .clr_i  (1'b0),
        .inc_i  (pulse_in),
        .dec_i  (w_fire),
        .cnt_o  (pending),
        .full_o (w_unused_pfull),
        .drop_o (w_drop)
    );

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            S_IDLE: begin
                if (pulse_in || (pending != '0)) state_d = S_FIRE;
            end
            S_FIRE: begin
                state_d = S_GAP;
                gcnt_d  = GAP_LOAD;
            end
            S_GAP: begin
                // New arrivals only add to pending; they never cut the gap short.
                gcnt_d = gcnt_q - GW'(1);
                if (gcnt_q == GW'(1)) begin
                    state_d = (pending != '0) ? S_FIRE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ovf_d = w_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gcnt_q  <= '0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            pulse_q <= (state_d == S_FIRE);
            ovf_q   <= ovf_d;
        end
    end

    assign pulse_out = pulse_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != S_IDLE) || (pending != '0);

`ifdef PACER_DROP_CNT_EN
    logic w_unused_dfull;
    logic w_unused_ddrop;

    pacer_sat_cnt #(
        .W      (DROP_CNT_W)
    ) u_drop_cnt (
        .clk    (clk_f),
        .rst_n  (rst_n),
        .clr_i  (clr_ovf),
        .inc_i  (w_drop),
        .dec_i  (1'b0),
        .cnt_o  (drop_cnt),
        .full_o (w_unused_dfull),
        .drop_o (w_unused_ddrop)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_pacer.sv
// ============================================================================
//  Module      : tb_pulse_pacer
//  Description : Directed self-checking bench for pulse_pacer (GAP=6, CNT_W=4)
//                including a toggle fast->slow synchronizer with clk_s=clk_f/3.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_pacer;

    logic       clk_f    = 1'b0;
    logic       clk_s    = 1'b0;
    logic       rst_n    = 1'b0;
    logic       pulse_in = 1'b0;
    logic       clr_ovf  = 1'b0;
    logic       pulse_out;
    logic       busy;
    logic       ovf;
    logic [3:0] pending;
`ifdef PACER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_pulse;
    int pend_log [200];
    int ovf_log  [200];
    int dcnt_log [200];

    pulse_pacer #(
        .GAP       (6),
        .CNT_W     (4)
    ) dut (
        .clk_f     (clk_f),
        .rst_n     (rst_n),
        .pulse_in  (pulse_in),
        .clr_ovf   (clr_ovf),
        .pulse_out (pulse_out),
        .pending   (pending),
        .busy      (busy),
`ifdef PACER_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .ovf       (ovf)
    );

    always #5 clk_f = ~clk_f;
    initial begin
        #2;
        forever #15 clk_s = ~clk_s;
    end

    // Toggle synchronizer model fed by pulse_out
    logic tog = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, sp_prev = 1'b0;
    logic sys_en = 1'b0;
    int   sp_hi = 0, sp_rise = 0;
    always @(posedge clk_f) if (pulse_out === 1'b1) tog <= ~tog;
    always @(posedge clk_s) begin
        if (sys_en) begin
            if (s2 ^ s3) sp_hi++;
            if ((s2 ^ s3) && !sp_prev) sp_rise++;
        end
        sp_prev = s2 ^ s3;
        s3 <= s2;
        s2 <= s1;
        s1 <= tog;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk_f cycle: drive inputs just after the edge, return at mid-cycle
    task automatic cyc(input logic pin, input logic clr);
        @(posedge clk_f);
        #1;
        pulse_in = pin;
        clr_ovf  = clr;
        @(negedge clk_f);
    endtask

    // pulse_in high for cycles t_lo..t_hi; n_exp accepted events expected
    task automatic run_burst(input string tag, input int t_lo, input int t_hi,
                             input int n_exp, input int n_cyc,
                             input int clr_a, input int clr_b);
        int last;
        int exp_p;
        int exp_b;
        last    = 11 + 6 * (n_exp - 1);
        n_pulse = 0;
        for (int c = 0; c < n_cyc; c++) begin
            cyc(c >= t_lo && c <= t_hi, c == clr_a || c == clr_b);
            exp_p = (c >= 11 && c <= last && ((c - 11) % 6) == 0) ? 1 : 0;
            exp_b = (c >= 11 && c <= last + 5) ? 1 : 0;
            chk_eq({tag, "_pulse_out"}, 32'(pulse_out), 32'(exp_p));
            chk_eq({tag, "_busy"}, 32'(busy), 32'(exp_b));
            pend_log[c] = int'(pending);
            ovf_log[c]  = int'(ovf);
`ifdef PACER_DROP_CNT_EN
            dcnt_log[c] = int'(drop_cnt);
`else
            dcnt_log[c] = 0;
`endif
            if (pulse_out === 1'b1) n_pulse++;
        end
        chk_eq({tag, "_npulse"}, 32'(n_pulse), 32'(n_exp));
    endtask

    initial begin
        int pmax;
        #3;
        chk_eq("rst_pulse_out", 32'(pulse_out), 32'd0);
        chk_eq("rst_pending", 32'(pending), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk_f);
        @(negedge clk_f);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);

        run_burst("single", 10, 10, 1, 25, -1, -1);
        chk_eq("single_pend11", 32'(pend_log[11]), 32'd1);
        chk_eq("single_pend12", 32'(pend_log[12]), 32'd0);

        run_burst("burst", 10, 13, 4, 40, -1, -1);
        pmax = 0;
        for (int c = 0; c < 40; c++) if (pend_log[c] > pmax) pmax = pend_log[c];
        chk_eq("burst_pend_peak", 32'(pmax), 32'd3);

        run_burst("ovf1", 10, 29, 19, 130, -1, -1);
        chk_eq("ovf1_pend28", 32'(pend_log[28]), 32'd15);
        chk_eq("ovf1_ovf28", 32'(ovf_log[28]), 32'd0);
        chk_eq("ovf1_ovf29", 32'(ovf_log[29]), 32'd1);
        chk_eq("ovf1_pend30", 32'(pend_log[30]), 32'd15);
        chk_eq("ovf1_sticky", 32'(ovf_log[129]), 32'd1);
`ifdef PACER_DROP_CNT_EN
        chk_eq("ovf1_drop_cnt", 32'(dcnt_log[129]), 32'd1);
`endif

        // clr_ovf coincides with the cycle-28 drop, then alone in cycle 29
        run_burst("ovf2", 10, 29, 19, 130, 28, 29);
        chk_eq("ovf2_ovf29", 32'(ovf_log[29]), 32'd1);
        chk_eq("ovf2_ovf30", 32'(ovf_log[30]), 32'd0);
        chk_eq("ovf2_pend30", 32'(pend_log[30]), 32'd15);
`ifdef PACER_DROP_CNT_EN
        chk_eq("ovf2_drop_cnt29", 32'(dcnt_log[29]), 32'd1);
        chk_eq("ovf2_drop_cnt30", 32'(dcnt_log[30]), 32'd0);
`endif

        // Asynchronous reset in the middle of a gap with a backlog
        for (int c = 0; c < 14; c++) cyc(c >= 10 && c <= 13, 1'b0);
        cyc(1'b0, 1'b0);
        chk_eq("mid_pending", 32'(pending), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_pulse_out", 32'(pulse_out), 32'd0);
        chk_eq("mid_rst_pending", 32'(pending), 32'd0);
        chk_eq("mid_rst_busy", 32'(busy), 32'd0);
        chk_eq("mid_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk_f);
        @(negedge clk_f);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b0, 1'b0);
            chk_eq("post_rst_pulse_out", 32'(pulse_out), 32'd0);
            chk_eq("post_rst_busy", 32'(busy), 32'd0);
        end

        sys_en = 1'b1;
        run_burst("sys", 10, 19, 10, 100, -1, -1);
        sys_en = 1'b0;
        chk_eq("sys_slow_pulses", 32'(sp_rise), 32'd10);
        chk_eq("sys_slow_hi_cycles", 32'(sp_hi), 32'd10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
